// File: rtl/pattern_scan_pkg.sv
// Shared definitions for the serial 1X10 pattern scanner.
package pattern_scan_pkg;

   localparam int unsigned WORD_W = 8;
   localparam int unsigned CNT_W  = 4;
   localparam int unsigned IDX_W  = $clog2(WORD_W);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

endpackage

// File: rtl/pattern_1x10_core.sv
// Serial 1X10 detector (oldest bit first, X don't-care, overlapping).
// Keeps a 3-bit history, hist[0] newest; match is combinational from history and the incoming bit.
module pattern_1x10_core (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic en,
   input  logic bit_in,   // "bit" is a reserved word, hence bit_in
   output logic match
);

   logic [2:0] r_hist;

   // history shift register: reset/clear win over shifting
   always_ff @(posedge clk) begin
      if (rst || clr) begin
         r_hist <= '0;
      end else if (en) begin
         r_hist <= {r_hist[1:0], bit_in};
      end
   end

   assign match = !bit_in & r_hist[0] & r_hist[2];

endmodule

// File: rtl/pattern_scan_ctrl.sv
// Scan controller: shifts an 8-bit word MSB first through the 1X10 detector,
// counting matches and recording the bit positions that completed them.
// Build option: define PATTERN_SCAN_CONT_EN to carry detector history across scans.
module pattern_scan_ctrl
   import pattern_scan_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              abort,
   input  logic [WORD_W-1:0] data_in,
   output logic              ready,
   output logic              busy,
   output logic              done,
   output logic [CNT_W-1:0]  match_cnt,
   output logic [WORD_W-1:0] match_pos
);

   state_t             r_state;
   state_t             w_next;
   logic [WORD_W-1:0]  r_word;
   logic [IDX_W-1:0]   r_bit_idx;
   logic [CNT_W-1:0]   r_match_cnt;
   logic [WORD_W-1:0]  r_match_pos;
   logic               r_ready;
   logic               r_busy;
   logic               r_done;
   logic               w_accept;
   logic               w_abort;
   logic               w_shift_en;
   logic               w_clr;
   logic               w_bit;
   logic               w_match;

   // state register
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // next-state and per-cycle control decode
   always_comb begin
      w_next     = r_state;
      w_accept   = 1'b0;
      w_abort    = 1'b0;
      w_shift_en = 1'b0;
      case (r_state)
         IDLE: begin
            if (start) begin
               w_accept = 1'b1;
               w_next   = SHIFT;
            end
         end
         SHIFT: begin
            if (abort) begin
               w_abort = 1'b1;
               w_next  = IDLE;
            end else begin
               w_shift_en = 1'b1;
               if (r_bit_idx == '0) begin
                  w_next = DONE;
               end
            end
         end
         DONE:    w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

`ifdef PATTERN_SCAN_CONT_EN
   assign w_clr = w_abort;
`else
   assign w_clr = w_abort | w_accept;
`endif

   assign w_bit = r_word[r_bit_idx];

   pattern_1x10_core u_core (
      .clk    (clk),
      .rst    (rst),
      .clr    (w_clr),
      .en     (w_shift_en),
      .bit_in (w_bit),
      .match  (w_match)
   );

   // word capture, bit index and match bookkeeping
   always_ff @(posedge clk) begin
      if (rst) begin
         r_word      <= '0;
         r_bit_idx   <= '0;
         r_match_cnt <= '0;
         r_match_pos <= '0;
      end else if (w_accept) begin
         r_word      <= data_in;
         r_bit_idx   <= IDX_W'(WORD_W - 1);
         r_match_cnt <= '0;
         r_match_pos <= '0;
      end else if (w_abort) begin
         r_bit_idx   <= '0;
         r_match_cnt <= '0;
         r_match_pos <= '0;
      end else if (w_shift_en) begin
         if (w_match) begin
            r_match_cnt            <= r_match_cnt + CNT_W'(1);
            r_match_pos[r_bit_idx] <= 1'b1;
         end
         r_bit_idx <= r_bit_idx - IDX_W'(1);
      end
   end

   // status flags registered from the next state so they line up with r_state
   always_ff @(posedge clk) begin
      if (rst) begin
         r_ready <= 1'b1;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         r_ready <= (w_next == IDLE);
         r_busy  <= (w_next == SHIFT);
         r_done  <= (w_next == DONE);
      end
   end

   assign ready     = r_ready;
   assign busy      = r_busy;
   assign done      = r_done;
   assign match_cnt = r_match_cnt;
   assign match_pos = r_match_pos;

endmodule

// File: tb/tb_pattern_scan_ctrl.sv
// Self-checking bench for pattern_scan_ctrl; expectations follow PATTERN_SCAN_CONT_EN when defined.
module tb_pattern_scan_ctrl;

`ifdef PATTERN_SCAN_CONT_EN
   localparam bit CONT = 1'b1;
`else
   localparam bit CONT = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start = 1'b0;
   logic       abort = 1'b0;
   logic [7:0] data_in = 8'h00;
   logic       ready, busy, done;
   logic [3:0] match_cnt;
   logic [7:0] match_pos;

   typedef struct packed {
      logic [3:0] cnt;
      logic [7:0] pos;
   } exp_t;

   exp_t        sb_q[$];
   int unsigned n_cmp = 0;
   int unsigned n_err = 0;

   pattern_scan_ctrl dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .abort     (abort),
      .data_in   (data_in),
      .ready     (ready),
      .busy      (busy),
      .done      (done),
      .match_cnt (match_cnt),
      .match_pos (match_pos)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // reference: 1X10 detector over one word, MSB first
   function automatic void model_scan(input logic [7:0] w, input logic [2:0] h_in,
                                      output logic [3:0] c, output logic [7:0] p,
                                      output logic [2:0] h_out);
      logic [2:0] h;
      h = CONT ? h_in : 3'b000;
      c = '0;
      p = '0;
      for (int i = 7; i >= 0; i--) begin
         if (!w[i] && h[0] && h[2]) begin
            c = c + 4'd1;
            p[i] = 1'b1;
         end
         h = {h[1:0], w[i]};
      end
      h_out = h;
   endfunction

   // stimulus only: one-cycle reset, ends on a falling edge
   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1; start = 1'b0; abort = 1'b0;
      @(negedge clk);
      rst = 1'b0;
   endtask

   // stimulus only: call on a falling edge while idle; returns on the falling edge after acceptance
   task automatic drive_start(input logic [7:0] d);
      start = 1'b1;
      data_in = d;
      @(negedge clk);
      start = 1'b0;
   endtask

   // observation only: n = falling edges after the acceptance falling edge until done
   task automatic wait_done(input int budget, output bit seen, output int n);
      seen = 1'b0;
      n = 0;
      for (int i = 1; i <= budget; i++) begin
         @(negedge clk);
         if (done === 1'b1) begin
            seen = 1'b1;
            n = i;
            break;
         end
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; start = 1'b1; abort = 1'b1; data_in = 8'hFF;
      repeat (3) @(negedge clk);
      n_cmp++;
      if ({ready, busy, done} !== 3'b100) begin
         n_err++; $display("FAIL reset_flags: got %b expected 100", {ready, busy, done});
      end
      n_cmp++;
      if ({match_cnt, match_pos} !== 12'h000) begin
         n_err++; $display("FAIL reset_results: got cnt=%0d pos=%b expected 0/0", match_cnt, match_pos);
      end
      rst = 1'b0; start = 1'b0; abort = 1'b0;
      @(negedge clk);
      n_cmp++;
      if ({ready, busy, done} !== 3'b100) begin
         n_err++; $display("FAIL reset_idle_hold: got %b expected 100", {ready, busy, done});
      end
   endtask

   task automatic test_basic();
      bit seen; int n; exp_t e;
      do_reset();
      sb_q.push_back({4'd2, 8'b0001_0001});
      drive_start(8'b1110_1110);
      data_in = 8'h00;
      n_cmp++;
      if ({ready, busy, done} !== 3'b010) begin
         n_err++; $display("FAIL basic_busy: got %b expected 010", {ready, busy, done});
      end
      wait_done(20, seen, n);
      e = sb_q.pop_front();
      n_cmp++;
      if (!seen || n != 8) begin
         n_err++; $display("FAIL basic_latency: got seen=%0d after %0d expected done after 8", seen, n);
      end
      n_cmp++;
      if ({ready, busy} !== 2'b00) begin
         n_err++; $display("FAIL basic_done_flags: got ready/busy=%b expected 00", {ready, busy});
      end
      n_cmp++;
      if (match_cnt !== e.cnt || match_pos !== e.pos) begin
         n_err++; $display("FAIL basic_result: got %0d/%b expected %0d/%b", match_cnt, match_pos, e.cnt, e.pos);
      end
      @(negedge clk);
      n_cmp++;
      if ({ready, busy, done} !== 3'b100) begin
         n_err++; $display("FAIL basic_ready_after: got %b expected 100", {ready, busy, done});
      end
      repeat (3) @(negedge clk);
      n_cmp++;
      if (match_cnt !== e.cnt || match_pos !== e.pos) begin
         n_err++; $display("FAIL basic_hold: got %0d/%b expected %0d/%b", match_cnt, match_pos, e.cnt, e.pos);
      end
   endtask

   task automatic test_alt();
      bit seen; int n; exp_t e;
      do_reset();
      sb_q.push_back({4'd3, 8'b0001_0101});
      drive_start(8'b1010_1010);
      wait_done(20, seen, n);
      e = sb_q.pop_front();
      n_cmp++;
      if (!seen || n != 8) begin
         n_err++; $display("FAIL alt_latency: got seen=%0d after %0d expected done after 8", seen, n);
      end
      n_cmp++;
      if (match_cnt !== e.cnt || match_pos !== e.pos) begin
         n_err++; $display("FAIL alt_result: got %0d/%b expected %0d/%b", match_cnt, match_pos, e.cnt, e.pos);
      end
      @(negedge clk);
   endtask

   task automatic test_back_to_back();
      bit seen; int n; exp_t e;
      do_reset();
      sb_q.push_back({4'd3, 8'b0001_0101});
      sb_q.push_back(CONT ? {4'd4, 8'b0101_0101} : {4'd3, 8'b0001_0101});
      for (int s = 0; s < 2; s++) begin
         drive_start(8'b1010_1010);
         wait_done(20, seen, n);
         e = sb_q.pop_front();
         n_cmp++;
         if (!seen || n != 8) begin
            n_err++; $display("FAIL b2b_latency[%0d]: got seen=%0d after %0d expected 8", s, seen, n);
         end
         n_cmp++;
         if (match_cnt !== e.cnt || match_pos !== e.pos) begin
            n_err++; $display("FAIL b2b_result[%0d]: got %0d/%b expected %0d/%b", s, match_cnt, match_pos, e.cnt, e.pos);
         end
         @(negedge clk);
         n_cmp++;
         if (ready !== 1'b1) begin
            n_err++; $display("FAIL b2b_ready[%0d]: got %b expected 1", s, ready);
         end
      end
   endtask

   task automatic test_abort();
      int cyc [2] = '{4, 7};
      bit seen; int n; exp_t e;
      for (int k = 0; k < 2; k++) begin
         do_reset();
         drive_start(8'b1010_1010);
         repeat (cyc[k] - 1) @(negedge clk);
         abort = 1'b1;
         @(negedge clk);
         abort = 1'b0;
         n_cmp++;
         if ({ready, busy, done} !== 3'b100) begin
            n_err++; $display("FAIL abort_flags[%0d]: got %b expected 100", cyc[k], {ready, busy, done});
         end
         n_cmp++;
         if ({match_cnt, match_pos} !== 12'h000) begin
            n_err++; $display("FAIL abort_clear[%0d]: got %0d/%b expected 0/0", cyc[k], match_cnt, match_pos);
         end
         wait_done(12, seen, n);
         n_cmp++;
         if (seen) begin
            n_err++; $display("FAIL abort_no_done[%0d]: got done after %0d expected none", cyc[k], n);
         end
      end
      sb_q.push_back({4'd3, 8'b0001_0101});
      drive_start(8'b1010_1010);
      wait_done(20, seen, n);
      e = sb_q.pop_front();
      n_cmp++;
      if (!seen || match_cnt !== e.cnt || match_pos !== e.pos) begin
         n_err++; $display("FAIL abort_rescan: got seen=%0d %0d/%b expected %0d/%b", seen, match_cnt, match_pos, e.cnt, e.pos);
      end
      @(negedge clk);
   endtask

   task automatic test_start_flood();
      int acc = 0, dn = 0, d1 = 0, d2 = 0;
      logic prev_busy;
      exp_t e;
      do_reset();
      prev_busy = busy;
      sb_q.push_back({4'd0, 8'h00});
      sb_q.push_back({4'd0, 8'h00});
      data_in = 8'h00;
      start = 1'b1;
      for (int i = 1; i <= 20; i++) begin
         @(negedge clk);
         if (busy && !prev_busy) acc++;
         prev_busy = busy;
         if (done) begin
            dn++;
            if (dn == 1) d1 = i; else d2 = i;
            if (sb_q.size() != 0) begin
               e = sb_q.pop_front();
               n_cmp++;
               if (match_cnt !== e.cnt || match_pos !== e.pos) begin
                  n_err++; $display("FAIL flood_result[%0d]: got %0d/%b expected %0d/%b", dn, match_cnt, match_pos, e.cnt, e.pos);
               end
            end
         end
         if (i == 20) start = 1'b0;
      end
      n_cmp++;
      if (acc != 2 || dn != 2) begin
         n_err++; $display("FAIL flood_count: got accepts=%0d dones=%0d expected 2/2", acc, dn);
      end
      n_cmp++;
      if (d1 != 9 || d2 != 19) begin
         n_err++; $display("FAIL flood_timing: got dones at %0d,%0d expected 9,19", d1, d2);
      end
      repeat (3) @(negedge clk);
      n_cmp++;
      if ({ready, busy} !== 2'b10) begin
         n_err++; $display("FAIL flood_idle: got ready/busy=%b expected 10", {ready, busy});
      end
   endtask

   task automatic test_rst_midscan();
      bit seen; int n;
      do_reset();
      drive_start(8'b1010_1010);
      repeat (4) @(negedge clk);
      rst = 1'b1; start = 1'b1; data_in = 8'hAA;
      @(negedge clk);
      rst = 1'b0; start = 1'b0;
      n_cmp++;
      if ({ready, busy, done} !== 3'b100) begin
         n_err++; $display("FAIL midrst_flags: got %b expected 100", {ready, busy, done});
      end
      n_cmp++;
      if ({match_cnt, match_pos} !== 12'h000) begin
         n_err++; $display("FAIL midrst_clear: got %0d/%b expected 0/0", match_cnt, match_pos);
      end
      wait_done(12, seen, n);
      n_cmp++;
      if (seen) begin
         n_err++; $display("FAIL midrst_no_done: got done after %0d expected none", n);
      end
   endtask

   task automatic test_random();
      logic [2:0] m_hist, h_next;
      logic [3:0] c;
      logic [7:0] p, d;
      bit seen; int n; exp_t e;
      do_reset();
      m_hist = 3'b000;
      for (int s = 0; s < 6; s++) begin
         d = 8'($urandom);
         model_scan(d, m_hist, c, p, h_next);
         m_hist = h_next;
         sb_q.push_back({c, p});
         drive_start(d);
         wait_done(20, seen, n);
         e = sb_q.pop_front();
         n_cmp++;
         if (!seen || n != 8) begin
            n_err++; $display("FAIL rand_latency[%0d]: got seen=%0d after %0d expected 8", s, seen, n);
         end
         n_cmp++;
         if (match_cnt !== e.cnt || match_pos !== e.pos) begin
            n_err++; $display("FAIL rand_result[%0d] data=%b: got %0d/%b expected %0d/%b", s, d, match_cnt, match_pos, e.cnt, e.pos);
         end
         @(negedge clk);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_alt();
      test_back_to_back();
      test_abort();
      test_start_flood();
      test_rst_midscan();
      test_random();
      n_cmp++;
      if (sb_q.size() != 0) begin
         n_err++; $display("FAIL scoreboard_drain: got %0d entries left expected 0", sb_q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/pattern_scan_ctrl.md
PATTERN_SCAN_CTRL -- requirements
Module: pattern_scan_ctrl

Interface
REQ-001 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-002 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-003 SHALL have port start  input  1  request to scan data_in; sampled only in IDLE.
REQ-004 SHALL have port abort  input  1  cancel an in-progress scan; sampled only in SHIFT.
REQ-005 SHALL have port data_in  input  8  word to scan, MSB shifted first.
REQ-006 SHALL have port ready  output  1  high in IDLE only.
REQ-007 SHALL have port busy  output  1  high in SHIFT only.
REQ-008 SHALL have port done  output  1  one-cycle pulse in DONE state.
REQ-009 SHALL have port match_cnt  output  4  number of matches in the last completed scan.
REQ-010 SHALL have port match_pos  output  8  bitmap; bit i set if the bit shifted from data_in[i] completed a match.

Function
REQ-011 SHALL detect the serial pattern 1X10 (oldest first; X don't-care), overlapping, via a 3-bit history hist[2:0] (hist[0] newest): match = !bit & hist[0] & hist[2].
REQ-012 SHALL implement FSM states IDLE, SHIFT, DONE, all registered outputs.
REQ-013 IDLE & start: latch data_in, bit_idx<=7, match_cnt<=0, match_pos<=0, go SHIFT; IDLE & !start: stay.
REQ-014 SHIFT: each cycle feed word[bit_idx] to the detector, shift it into hist, on match increment match_cnt and set match_pos[bit_idx]; decrement bit_idx.
REQ-015 SHIFT with bit_idx==0 (after processing) SHALL go DONE; exactly 8 SHIFT cycles per scan.
REQ-016 DONE SHALL assert done for exactly one cycle then go IDLE unconditionally.
REQ-017 Latency: start sampled at edge N -> done high in cycle N+9 -> ready high at N+10.
REQ-018 start while busy or in DONE SHALL be ignored (no queueing); data_in changes after acceptance SHALL have no effect.
REQ-019 abort in SHIFT SHALL take priority over bit processing: go IDLE, no done pulse, match_cnt and match_pos cleared to 0, hist cleared.
REQ-020 match_cnt/match_pos SHALL hold from DONE until the next accepted start; max value 4, no saturation logic needed.

Reset
REQ-021 rst SHALL force IDLE, hist=0, bit_idx=0, match_cnt=0, match_pos=0, done=0, busy=0, ready=1 on the next edge.
REQ-022 rst SHALL override start and abort in the same cycle; rst mid-scan SHALL drop the scan with no done pulse.

Configuration
REQ-023 Macro PATTERN_SCAN_CONT_EN SHALL select history carry-over.
REQ-024 Defined: hist SHALL persist across scans (cleared only by rst/abort) so matches may span word boundaries.
REQ-025 Undefined: hist SHALL be cleared to 0 on every accepted start; matches are confined to one word.

Structure
REQ-026 Shared package pattern_scan_pkg SHALL hold the FSM state encoding (IDLE=2'd0, SHIFT=2'd1, DONE=2'd2), WORD_W=8 and CNT_W=4.
REQ-027 Detector SHALL be sub-module pattern_1x10_core (inputs clk, rst, clr, en, bit; output match combinational from hist and bit; hist updated when en).
REQ-028 Unused state encoding SHALL fall back to IDLE.

Verification
REQ-029 Reset then start with data_in=8'b1110_1110 -> done at N+9, match_cnt=2, match_pos=8'b0001_0001.
REQ-030 start with 8'b1010_1010 after reset -> match_cnt=3, match_pos=8'b0001_0101.
REQ-031 Two back-to-back scans of 8'b1010_1010 -> second scan match_cnt=4, match_pos=8'b0101_0101 with PATTERN_SCAN_CONT_EN; 3 and 8'b0001_0101 without.
REQ-032 abort asserted in 4th SHIFT cycle -> ready next cycle, no done, match_cnt=0, match_pos=0.
REQ-033 start pulsed every cycle for 20 cycles with data 8'h00 -> exactly two scans accepted (N, N+10), match_cnt=0 each.
REQ-034 rst asserted in 5th SHIFT cycle together with start -> IDLE, all outputs at reset values, no done.
